// File: rtl/proj_fm_pool.sv
// N-deep circular pool of fragment buffers: producer fills the write buffer, consumer windows the oldest full buffer.
// Fragment latency 1 cycle (2 with FM_RD_PIPE_EN); producer is stalled via in_ready while every buffer is full.
module proj_fm_pool #(
    parameter int BUFFER_COUNT = 4,
    parameter int BUF_DEPTH    = 64,
    parameter int DATA_BITS    = 2,
    parameter int FRAG_SYMS    = 16,
    parameter int IDX_BITS     = $clog2(BUF_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_BITS-1:0]            in_data,
    input  logic                            rd_req,
    input  logic [IDX_BITS-1:0]             rd_idx,
    input  logic                            rd_release,
    output logic                            out_valid,
    output logic [FRAG_SYMS*DATA_BITS-1:0]  out_data,
    output logic [$clog2(BUFFER_COUNT):0]   full_count
);
    localparam int BB = $clog2(BUFFER_COUNT);
    localparam int AB = $clog2(BUF_DEPTH);
    localparam int CB = BB + 1;
    localparam int PW = IDX_BITS + 2;

    logic [BB-1:0]        wbuf_q, wbuf_d, rbuf_q, rbuf_d;
    logic [AB-1:0]        waddr_q, waddr_d;
    logic [CB-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] mem [BUFFER_COUNT*BUF_DEPTH];

    logic wr_fire, wr_last, rel_fire, rd_fire;

    assign in_ready   = (cnt_q < CB'(BUFFER_COUNT));
    assign full_count = cnt_q;
    assign wr_fire    = in_valid && in_ready;
    assign wr_last    = wr_fire && (waddr_q == AB'(BUF_DEPTH - 1));
    assign rel_fire   = rd_release && (cnt_q != '0);
    assign rd_fire    = rd_req && (cnt_q != '0);

    always_comb begin
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        if (wr_fire)  waddr_d = waddr_q + AB'(1);
        if (wr_last)  wbuf_d  = wbuf_q + BB'(1);
        if (rel_fire) rbuf_d  = rbuf_q + BB'(1);
        case ({wr_last, rel_fire})
            2'b10:   cnt_d = cnt_q + CB'(1);
            2'b01:   cnt_d = cnt_q - CB'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wbuf_q, waddr_q}] <= in_data;
    end

    // Index is sign-extended by two bits so start+k can never wrap back into range.
    logic [PW-1:0]                         pos [FRAG_SYMS];
    logic [FRAG_SYMS-1:0][DATA_BITS-1:0]   raw_sym;
    logic [FRAG_SYMS-1:0]                  in_rng;

    always_comb begin
        raw_sym = '0;
        in_rng  = '0;
        for (int k = 0; k < FRAG_SYMS; k++) begin
            pos[k]     = {{2{rd_idx[IDX_BITS-1]}}, rd_idx} + PW'(k);
            in_rng[k]  = (pos[k][PW-1:AB] == '0);
            raw_sym[k] = mem[{rbuf_q, pos[k][AB-1:0]}];
        end
    end

    function automatic logic [FRAG_SYMS*DATA_BITS-1:0] pad(
        input logic [FRAG_SYMS-1:0][DATA_BITS-1:0] s,
        input logic [FRAG_SYMS-1:0]                m
    );
        pad = '0;
        for (int k = 0; k < FRAG_SYMS; k++)
            pad[k*DATA_BITS +: DATA_BITS] = m[k] ? s[k] : '0;
    endfunction

    logic                           out_valid_q;
    logic [FRAG_SYMS*DATA_BITS-1:0] out_data_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FM_RD_PIPE_EN
    logic [FRAG_SYMS-1:0][DATA_BITS-1:0] raw_q;
    logic [FRAG_SYMS-1:0]                rng_q;
    logic                                v1_q;

    // Raw mux output and range mask are captured at the request cycle; padding happens one stage later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q       <= '0;
            rng_q       <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            v1_q        <= rd_fire;
            out_valid_q <= v1_q;
            if (rd_fire) begin
                raw_q <= raw_sym;
                rng_q <= in_rng;
            end
            if (v1_q) out_data_q <= pad(raw_q, rng_q);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_fire;
            if (rd_fire) out_data_q <= pad(raw_sym, in_rng);
        end
    end
`endif

endmodule

// File: tb/tb_proj_fm_pool.sv
module tb_proj_fm_pool;
    localparam int NB = 4;
`ifdef FM_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_data;
    logic        rd_req, rd_release, out_valid;
    logic [6:0]  rd_idx;
    logic [31:0] out_data;
    logic [2:0]  full_count;

    int tests = 0;
    int fails = 0;

    proj_fm_pool dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_release(rd_release),
        .out_valid(out_valid), .out_data(out_data), .full_count(full_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: full buffers held as a FIFO of whole 64-symbol images.
    logic [127:0] fullq[$];
    logic [127:0] wv;
    int           wcnt;
    logic         pv [LAT+1];
    logic [31:0]  pd [LAT+1];

    function automatic logic [31:0] frag(input logic [127:0] b, input int idx);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            int p;
            p = idx + k;
            if (p >= 0 && p < 64) r[k*2 +: 2] = b[p*2 +: 2];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fullq.delete();
            wcnt = 0;
            wv   = '0;
            for (int i = 0; i <= LAT; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
        end else begin
            bit fire, rel, acc;
            logic [31:0] f;
            fire = rd_req && fullq.size() > 0;
            f    = fire ? frag(fullq[0], int'($signed(rd_idx))) : 32'h0;
            acc  = in_valid && fullq.size() < NB;
            rel  = rd_release && fullq.size() > 0;
            for (int i = LAT; i > 1; i--) begin
                pv[i] = pv[i-1];
                if (pv[i-1]) pd[i] = pd[i-1];
            end
            pv[1] = fire;
            if (fire) pd[1] = f;
            if (rel) void'(fullq.pop_front());
            if (acc) begin
                wv[wcnt*2 +: 2] = in_data;
                wcnt++;
                if (wcnt == 64) begin
                    fullq.push_back(wv);
                    wcnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready", in_ready, (fullq.size() < NB) ? 1 : 0);
        chk("m_full_count", full_count, fullq.size());
        chk("m_out_valid", out_valid, pv[LAT]);
        chk("m_out_data", out_data, pd[LAT]);
    end

    task automatic push(input logic [1:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = s;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input bit lit);
        rd_req = 1'b1;
        rd_idx = 7'(idx);
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        if (lit) begin
            chk("rd_valid", out_valid, 1);
            chk("rd_data", out_data, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        rd_req = 1'b0; rd_idx = '0; rd_release = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_full_count", full_count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 64; i++) push(2'(i % 4));
        in_valid = 1'b0;
        chk("fill1_count", full_count, 1);
        chk("fill1_ready", in_ready, 1);

        rd(-3, 32'h39393900, 1);
        rd(56, 32'h0000E4E4, 1);
        rd(63, 32'h00000003, 1);
        rd(0,  32'hE4E4E4E4, 1);
        rd(-20, 32'h00000000, 1);

        for (int i = 0; i < 63; i++) push(2'($urandom_range(0, 3)));
        rd_release = 1'b1;
        push(2'($urandom_range(0, 3)));
        rd_release = 1'b0;
        in_valid = 1'b0;
        chk("cpl_rel_count", full_count, 1);
        rd(7, 0, 0);
        rd(-5, 0, 0);

        for (int i = 0; i < 192; i++) push(2'($urandom_range(0, 3)));
        chk("full4_count", full_count, 4);
        chk("full4_ready", in_ready, 0);

        in_data = 2'd2;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_ready", in_ready, 0);
        end
        chk("hold_count", full_count, 4);
        rd_release = 1'b1;
        @(posedge clk); #1;
        rd_release = 1'b0;
        chk("rel_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rel_count", full_count, 3);
        for (int i = 0; i < 63; i++) push(2'($urandom_range(0, 3)));
        in_valid = 1'b0;
        chk("refill_count", full_count, 4);

        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_release = 1'b1; rd_idx = 7'(5 + i * 10);
            @(posedge clk); #1;
        end
        rd_req = 1'b0; rd_release = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("drain_count", full_count, 0);

        rd_req = 1'b1; rd_release = 1'b1; rd_idx = 7'd0;
        @(posedge clk); #1;
        rd_req = 1'b0; rd_release = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        chk("empty_valid", out_valid, 0);
        chk("empty_count", full_count, 0);

        for (int i = 0; i < 74; i++) push(2'(i % 4));
        in_valid = 1'b0;
        rd(0, 32'hE4E4E4E4, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", full_count, 0);
        chk("arst_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) push(2'((i + 1) % 4));
        in_valid = 1'b0;
        chk("fresh_count", full_count, 1);
        rd(0, 32'h39393939, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
